// File: rtl/store_trace_monitor_pkg.sv
// Shared types for the store trace monitor: trace entry layout, verdict states
// and the per-store verdict classification.
package store_mon_pkg;

  localparam int MON_CNT_W = 8;

  // The cycle field width is fixed here; the top's CNT_W must equal MON_CNT_W.
  typedef struct packed {
    logic [31:0]          adr;
    logic [31:0]          data;
    logic [MON_CNT_W-1:0] cycle;
  } trace_entry_t;

  typedef enum logic [1:0] {
    MON_RUN     = 2'd0,
    MON_PASS    = 2'd1,
    MON_FAIL    = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_e;

  // Verdict implied by a single store; MON_RUN means the store is tolerated.
  function automatic mon_state_e store_verdict(
    input logic [31:0] adr,
    input logic [31:0] data,
    input logic [31:0] done_addr,
    input logic [31:0] done_value,
    input logic [31:0] scratch_addr
  );
    if (adr == done_addr) begin
      return (data == done_value) ? MON_PASS : MON_FAIL;
    end
    if (adr == scratch_addr) begin
      return MON_RUN;
    end
    return MON_FAIL;
  endfunction

endpackage

// File: rtl/store_trace_monitor_sync_fifo.sv
// First-word-fall-through FIFO of arbitrary packed type; the head is visible
// whenever o_valid is high. Pushes into a full FIFO are refused unless a pop
// happens in the same cycle.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_valid,
  output logic o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & o_valid;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/store_trace_monitor.sv
// Traces every data-memory store into a FWFT FIFO tagged with the cycle count,
// and decides a pass/fail/timeout verdict for the running program.
module store_trace_monitor
  import store_mon_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter int          CNT_W        = MON_CNT_W,
  parameter logic [31:0] DONE_ADDR    = 32'd100,
  parameter logic [31:0] DONE_VALUE   = 32'd10,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          TIMEOUT_CYC  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write_i,
  input  logic [31:0]      data_adr_i,
  input  logic [31:0]      write_data_i,
  output logic             trc_valid_o,
  input  logic             trc_ready_i,
  output logic [31:0]      trc_adr_o,
  output logic [31:0]      trc_data_o,
  output logic [CNT_W-1:0] trc_cycle_o,
  output logic             overflow_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o
);

  logic [CNT_W-1:0] r_cnt;
  mon_state_e       r_state;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic             r_done;
  logic             r_overflow;
  trace_entry_t     w_push_entry;
  trace_entry_t     w_head;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  mon_state_e       w_store_verdict;

  assign w_push_entry    = '{adr: data_adr_i, data: write_data_i, cycle: r_cnt};
  assign w_pop           = w_valid & trc_ready_i;
  assign w_store_verdict = store_verdict(data_adr_i, write_data_i, DONE_ADDR, DONE_VALUE, SCRATCH_ADDR);

  sync_fifo #(
    .T     (trace_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (mem_write_i),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_valid),
    .o_full  (w_full)
  );

  // Head fields are forced to zero while empty so every output reads 0 in reset.
  assign trc_valid_o = w_valid;
  assign trc_adr_o   = w_valid ? w_head.adr   : '0;
  assign trc_data_o  = w_valid ? w_head.data  : '0;
  assign trc_cycle_o = w_valid ? w_head.cycle : '0;
  assign overflow_o  = r_overflow;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign timeout_o   = r_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (mem_write_i & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  // Verdict FSM: a store's verdict takes precedence over a same-cycle timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= MON_RUN;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else if (r_state == MON_RUN) begin
      if (mem_write_i) begin
        if (w_store_verdict != MON_RUN) begin
          r_state <= w_store_verdict;
          r_pass  <= (w_store_verdict == MON_PASS);
          r_fail  <= (w_store_verdict == MON_FAIL);
          r_done  <= 1'b1;
        end
      end else if (r_cnt == CNT_W'(TIMEOUT_CYC)) begin
        r_state   <= MON_TIMEOUT;
        r_timeout <= 1'b1;
        r_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench for store_trace_monitor: verdicts, trace ordering, overflow,
// full-FIFO push/pop and asynchronous reset.
module tb_store_trace_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [31:0] data_adr_i = '0;
  logic [31:0] write_data_i = '0;
  logic        trc_ready_i = 1'b0;
  logic        trc_valid_o;
  logic [31:0] trc_adr_o;
  logic [31:0] trc_data_o;
  logic [7:0]  trc_cycle_o;
  logic        overflow_o;
  logic        done_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;

  int checks = 0;
  int passes = 0;

  store_trace_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write_i  (mem_write_i),
    .data_adr_i   (data_adr_i),
    .write_data_i (write_data_i),
    .trc_valid_o  (trc_valid_o),
    .trc_ready_i  (trc_ready_i),
    .trc_adr_o    (trc_adr_o),
    .trc_data_o   (trc_data_o),
    .trc_cycle_o  (trc_cycle_o),
    .overflow_o   (overflow_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write_i  = 1'b1;
    data_adr_i   = a;
    write_data_i = d;
  endtask

  task automatic idle();
    mem_write_i  = 1'b0;
    data_adr_i   = '0;
    write_data_i = '0;
  endtask

  task automatic do_reset();
    idle();
    trc_ready_i = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    idle();
    tick();
    chk("rst_valid", {31'd0, trc_valid_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
    chk("rst_adr", trc_adr_o, 32'd0);

    // 1: scratch store then passing store, drained
    do_reset();
    trc_ready_i = 1'b1;
    store(32'd96, 32'd5);
    tick();
    chk("t1_valid0", {31'd0, trc_valid_o}, 32'd1);
    chk("t1_adr0", trc_adr_o, 32'd96);
    chk("t1_data0", trc_data_o, 32'd5);
    chk("t1_cyc0", {24'd0, trc_cycle_o}, 32'd0);
    chk("t1_done_early", {31'd0, done_o}, 32'd0);
    store(32'd100, 32'd10);
    tick();
    idle();
    chk("t1_pass", {31'd0, pass_o}, 32'd1);
    chk("t1_done", {31'd0, done_o}, 32'd1);
    chk("t1_adr1", trc_adr_o, 32'd100);
    chk("t1_data1", trc_data_o, 32'd10);
    chk("t1_cyc1", {24'd0, trc_cycle_o}, 32'd1);
    tick();
    chk("t1_empty", {31'd0, trc_valid_o}, 32'd0);

    // 2: wrong value at DONE_ADDR fails, later correct store doesn't change it
    do_reset();
    trc_ready_i = 1'b1;
    store(32'd100, 32'd7);
    tick();
    chk("t2_fail", {31'd0, fail_o}, 32'd1);
    chk("t2_nopass", {31'd0, pass_o}, 32'd0);
    store(32'd100, 32'd10);
    tick();
    idle();
    chk("t2_fail_frozen", {31'd0, fail_o}, 32'd1);
    chk("t2_pass_frozen", {31'd0, pass_o}, 32'd0);

    // 3: illegal address fails but is still traced
    do_reset();
    store(32'd64, 32'd1);
    tick();
    idle();
    chk("t3_fail", {31'd0, fail_o}, 32'd1);
    chk("t3_valid", {31'd0, trc_valid_o}, 32'd1);
    chk("t3_adr", trc_adr_o, 32'd64);
    chk("t3_data", trc_data_o, 32'd1);

    // 4a: no stores -> timeout after the counter reaches 24
    do_reset();
    repeat (24) tick();
    chk("t4_no_timeout_yet", {31'd0, timeout_o}, 32'd0);
    tick();
    chk("t4_timeout", {31'd0, timeout_o}, 32'd1);
    chk("t4_done", {31'd0, done_o}, 32'd1);
    chk("t4_nopass", {31'd0, pass_o}, 32'd0);

    // 4b: passing store exactly on cycle 24 beats the timeout
    do_reset();
    trc_ready_i = 1'b1;
    repeat (24) tick();
    store(32'd100, 32'd10);
    tick();
    idle();
    chk("t4b_pass", {31'd0, pass_o}, 32'd1);
    chk("t4b_timeout", {31'd0, timeout_o}, 32'd0);
    chk("t4b_cycle", {24'd0, trc_cycle_o}, 32'd24);

    // 5: fill, full push+pop, then drop, then drain 8 entries
    do_reset();
    for (int i = 0; i < 8; i++) begin
      store(32'd96, i);
      tick();
    end
    chk("t5_full_no_ovf", {31'd0, overflow_o}, 32'd0);
    chk("t5_head0", trc_data_o, 32'd0);
    trc_ready_i = 1'b1;
    store(32'd96, 32'd8);
    tick();
    chk("t5_pushpop_no_ovf", {31'd0, overflow_o}, 32'd0);
    chk("t5_head1", trc_data_o, 32'd1);
    trc_ready_i = 1'b0;
    store(32'd96, 32'd9);
    tick();
    idle();
    chk("t5_ovf", {31'd0, overflow_o}, 32'd1);
    trc_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t5_drain_data%0d", i), trc_data_o, i);
      chk($sformatf("t5_drain_cyc%0d", i), {24'd0, trc_cycle_o}, i);
      tick();
    end
    chk("t5_drained", {31'd0, trc_valid_o}, 32'd0);
    chk("t5_ovf_sticky", {31'd0, overflow_o}, 32'd1);
    chk("t5_no_verdict", {31'd0, done_o}, 32'd0);

    // 6: asynchronous reset mid-trace
    do_reset();
    store(32'd64, 32'd1);
    tick();
    store(32'd96, 32'd2);
    tick();
    idle();
    chk("t6_pre_fail", {31'd0, fail_o}, 32'd1);
    chk("t6_pre_valid", {31'd0, trc_valid_o}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, trc_valid_o}, 32'd0);
    chk("t6_rst_fail", {31'd0, fail_o}, 32'd0);
    chk("t6_rst_done", {31'd0, done_o}, 32'd0);
    chk("t6_rst_data", trc_data_o, 32'd0);
    tick();
    reset = 1'b1;
    store(32'd96, 32'h55);
    tick();
    idle();
    chk("t6_new_valid", {31'd0, trc_valid_o}, 32'd1);
    chk("t6_new_data", trc_data_o, 32'h55);
    chk("t6_new_cycle", {24'd0, trc_cycle_o}, 32'd0);
    chk("t6_new_fail", {31'd0, fail_o}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
